// File: rtl/bitop_batch_sequencer.sv
// Batch buffer + sequencer: collects input vectors, then streams f(vector) results
// one per handshake through a fixed XOR/inverter bit-op datapath.
module bitop_batch_sequencer #(
    parameter int unsigned IN_W  = 20,
    parameter int unsigned OUT_W = 10,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [CNT_W-1:0] out_index,
    output logic [CNT_W-1:0] vec_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    // Only v[8:1] feeds the datapath, so only those bits are buffered.
    localparam int unsigned VW = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [OUT_W-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [VW-1:0]    buf_q [DEPTH];
    logic             wr_en;
    logic [AW-1:0]    rd_addr;
    logic [VW-1:0]    rd_vec;
    logic [OUT_W-1:0] rd_res;
    logic [CNT_W-1:0] idx_nxt;
    logic             hs;
    logic             unused_in_bits;

    assign unused_in_bits = ^{in_data[IN_W-1:VW+1], in_data[0]};

    // s holds v[8:1]: two XOR lanes on v[2:1]^v[4:3], four inverters on v[8:5].
    function automatic logic [OUT_W-1:0] bitop_f(input logic [VW-1:0] s);
        logic [OUT_W-1:0] r;
        r      = '0;
        r[1:0] = s[1:0] ^ s[3:2];
        r[5:2] = ~s[7:4];
        return r;
    endfunction

    assign idx_nxt = idx_q + CNT_W'(1);
    assign hs      = valid_q && out_ready;
    assign rd_addr = (state_q == ST_RUN) ? idx_nxt[AW-1:0] : AW'(0);
    assign rd_vec  = buf_q[rd_addr];
    assign rd_res  = bitop_f(rd_vec);

    // Next-state, load control and result sequencing.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        idx_d    = idx_q;
        data_d   = data_q;
        valid_d  = valid_q;
        wr_en    = 1'b0;
        in_ready = 1'b0;

        case (state_q)
            ST_IDLE: begin
                in_ready = (count_q < CNT_W'(DEPTH)) && !start;
                if (start) begin
                    if (count_q != '0) begin
                        state_d = ST_RUN;
                        idx_d   = '0;
                        data_d  = rd_res;
                        valid_d = 1'b1;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else if (in_valid && in_ready) begin
                    wr_en   = 1'b1;
                    count_d = count_q + CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (hs) begin
                    if (idx_nxt == count_q) begin
                        valid_d = 1'b0;
                        count_d = '0;
                        state_d = ST_DONE;
                    end else begin
                        idx_d  = idx_nxt;
                        data_d = rd_res;
                    end
                end
            end
            ST_DONE: begin
                count_d = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Vector storage needs no reset; contents are only read below count_q.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            buf_q[count_q[AW-1:0]] <= in_data[VW:1];
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_index = idx_q;
    assign vec_count = count_q;

endmodule

// File: tb/tb_bitop_batch_sequencer.sv
// Scoreboard bench for bitop_batch_sequencer: loads push expected results,
// a negedge monitor checks every presented result against the queue head.
module tb_bitop_batch_sequencer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [19:0] in_data;
    logic        start;
    logic        busy;
    logic        done;
    logic        out_valid;
    logic        out_ready;
    logic [9:0]  out_data;
    logic [3:0]  out_index;
    logic [3:0]  vec_count;

    typedef struct packed {
        logic [9:0] data;
        logic [3:0] idx;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   mcount = 0;

    bitop_batch_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .vec_count (vec_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Result monitor: head of queue must match whenever out_valid is high (covers stalls).
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: data=%h idx=%0d with empty queue", out_data, out_index);
            end else begin
                e = sb[0];
                if (out_data !== e.data || out_index !== e.idx) begin
                    errors++;
                    $display("FAIL sb_result: got data=%h idx=%0d expected data=%h idx=%0d",
                             out_data, out_index, e.data, e.idx);
                end
                if (out_ready) void'(sb.pop_front());
            end
        end
    end

    task automatic load(input logic [19:0] v, input logic [9:0] e);
        in_data  = v;
        in_valid = 1'b1;
        #1;
        chk("in_ready_load", 32'(in_ready), 32'(1));
        if (in_ready) begin
            sb.push_back('{data: e, idx: 4'(mcount)});
            mcount++;
        end
        tick();
        in_valid = 1'b0;
        chk("vec_count_load", 32'(vec_count), 32'(mcount));
    endtask

    // mode 0: out_ready always high; mode 1: out_ready pattern 1,0,0,1,0,0,...
    task automatic run_batch(input int n, input int mode);
        int   hs;
        int   cyc;
        logic hs_now;
        hs  = 0;
        cyc = 0;
        start = 1'b1;
        #1;
        chk("in_ready_start", 32'(in_ready), 32'(0));
        tick();
        start    = 1'b0;
        in_valid = 1'b0;
        if (n == 0) begin
            chk("empty_done", 32'(done), 32'(1));
            chk("empty_valid", 32'(out_valid), 32'(0));
            chk("empty_busy", 32'(busy), 32'(0));
        end else begin
            chk("run_busy", 32'(busy), 32'(1));
            chk("run_valid_lat1", 32'(out_valid), 32'(1));
            chk("vec_count_run", 32'(vec_count), 32'(n));
            while (hs < n && cyc < 100) begin
                out_ready = (mode == 0) || (cyc % 3 == 0);
                #1;
                hs_now = out_valid && out_ready;
                if (hs < n - 1 || !hs_now) begin
                    checks++;
                    if (done !== 1'b0) begin
                        errors++;
                        $display("FAIL early_done: done=%b at cycle %0d", done, cyc);
                    end
                end
                tick();
                cyc++;
                if (hs_now) hs++;
            end
            if (cyc >= 100) chk("run_timeout", 32'(hs), 32'(n));
            out_ready = 1'b0;
            chk("done_pulse", 32'(done), 32'(1));
            chk("valid_after_last", 32'(out_valid), 32'(0));
            chk("busy_after_last", 32'(busy), 32'(0));
            if (mode == 0) chk("run_cycles", 32'(cyc), 32'(n));
        end
        chk("vec_count_done", 32'(vec_count), 32'(0));
        tick();
        chk("done_one_cycle", 32'(done), 32'(0));
        chk("in_ready_idle", 32'(in_ready), 32'(1));
        chk("sb_drained", 32'(sb.size()), 32'(0));
        mcount = 0;
    endtask

    logic [19:0] fv [10] = '{20'h00000, 20'h00006, 20'h00002, 20'h00008, 20'h00020,
                             20'h00100, 20'h00001, 20'hFFE00, 20'h0001E, 20'h001E0};
    logic [9:0]  fe [10] = '{10'h03C, 10'h03F, 10'h03D, 10'h03D, 10'h038,
                             10'h01C, 10'h03C, 10'h03C, 10'h03C, 10'h000};

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        start     = 1'b0;
        out_ready = 1'b0;
        #2;
        chk("rst_in_ready", 32'(in_ready), 32'(1));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_out_data", 32'(out_data), 32'(0));
        chk("rst_out_index", 32'(out_index), 32'(0));
        chk("rst_vec_count", 32'(vec_count), 32'(0));
        #10;
        rst_n = 1'b1;
        tick();

        // Three-vector batch, sink always ready.
        load(20'h00000, 10'h03C);
        load(20'h00006, 10'h03F);
        load(20'h00002, 10'h03D);
        run_batch(3, 0);

        // Four vectors with a stalling sink.
        load(20'h001E0, 10'h000);
        load(20'hFFFFF, 10'h000);
        load(20'h0000A, 10'h03C);
        load(20'h0001E, 10'h03C);
        run_batch(4, 1);

        // Ten offered back-to-back; only eight fit.
        for (int i = 0; i < 10; i++) begin
            in_data  = fv[i];
            in_valid = 1'b1;
            #1;
            chk("in_ready_fill", 32'(in_ready), 32'(mcount < 8));
            if (in_ready) begin
                sb.push_back('{data: fe[i], idx: 4'(mcount)});
                mcount++;
            end
            tick();
        end
        chk("vec_count_full", 32'(vec_count), 32'(8));
        chk("in_ready_full", 32'(in_ready), 32'(0));
        in_valid = 1'b0;
        run_batch(8, 0);

        // Empty batch.
        chk("vec_count_empty", 32'(vec_count), 32'(0));
        run_batch(0, 0);

        // start and in_valid together: start wins, vector not counted.
        load(20'h00020, 10'h038);
        load(20'h00100, 10'h01C);
        in_data  = 20'h00006;
        in_valid = 1'b1;
        run_batch(2, 0);

        // Reset in the middle of a five-vector run.
        for (int i = 0; i < 5; i++) load(fv[i], fe[i]);
        out_ready = 1'b1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        out_ready = 1'b0;
        chk("pre_rst_index", 32'(out_index), 32'(2));
        rst_n = 1'b0;
        sb.delete();
        mcount = 0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'(0));
        chk("mid_rst_busy", 32'(busy), 32'(0));
        chk("mid_rst_count", 32'(vec_count), 32'(0));
        chk("mid_rst_done", 32'(done), 32'(0));
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_done", 32'(done), 32'(0));
        load(20'h00006, 10'h03F);
        run_batch(1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
